// File: rtl/cdc_uart_tx.sv
// cdc_uart_tx -- transmit half of the USB-CDC-to-UART bridge.
//
// Host bytes from the CDC OUT stream are queued in a DEPTH-byte FIFO and
// serialised 8N1 / 8E1 / 8O1 (one or two stop bits) on UART_TX. UART_DE
// drives an RS-485 transceiver, with de_guard cycles of lead before the
// first start bit of a burst and de_guard cycles of trail after the last
// stop bit. Back-to-back bytes inside a burst are sent with no gap. The
// baud divisor, parity mode, stop-bit count and guard time are latched
// when a burst begins and are held until it ends.
//
// Ports:
//   hclk, reset          clock; synchronous active-high reset
//   s_tvalid/s_tready/s_tdata   CDC OUT byte stream (s_tready registered)
//   baud_div             hclk cycles per bit (0 behaves as 1)
//   parity_mode          00/11 none, 01 even, 10 odd
//   two_stop             1 = two stop bits
//   de_guard             DE lead/trail in hclk cycles
//   UART_TX, UART_DE     serial data (idle high) and driver enable, both flops
//   busy                 FSM active or FIFO holding data
//   fifo_level           bytes currently held in the FIFO
//
// Optional feature, macro CDC_UART_TX_BREAK_EN: adds input break_req and a
// BREAK state that holds TX low (DE high) while break_req stays high, then
// one bit time of TX high before the usual end-of-stop decision.

module cdc_uart_tx #(
    parameter int DEPTH = 64,
    parameter int DIV_W = 16
) (
    input  logic                    hclk,
    input  logic                    reset,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [7:0]              s_tdata,
    input  logic [DIV_W-1:0]        baud_div,
    input  logic [1:0]              parity_mode,
    input  logic                    two_stop,
    input  logic [7:0]              de_guard,
`ifdef CDC_UART_TX_BREAK_EN
    input  logic                    break_req,
`endif
    output logic                    UART_TX,
    output logic                    UART_DE,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_level
);

    localparam int AW = $clog2(DEPTH);
    // One down-counter serves bit timing and guard timing.
    localparam int CW = (DIV_W > 8) ? DIV_W : 8;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_START, S_DATA, S_PARITY, S_STOP, S_TRAIL
`ifdef CDC_UART_TX_BREAK_EN
        , S_BREAK
`endif
    } state_t;

    // ---------------- FIFO ----------------
    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic        s_tready_q;
    logic        push, pop, empty;
    logic [AW:0] level;

    assign push  = s_tvalid && s_tready_q;
    assign level = wptr_q - rptr_q;
    assign empty = (level == '0);
    assign wptr_d = wptr_q + (AW+1)'(push);
    assign rptr_d = rptr_q + (AW+1)'(pop);

    // ---------------- FSM state ----------------
    state_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]   bit_q, bit_d;
    logic         stop2_q, stop2_d;        // first stop bit done, second pending
    logic [7:0]   sh_q;
    logic         tx_q, tx_d, de_q, de_d;
    logic         latch, stop_end, cnt_last;
`ifdef CDC_UART_TX_BREAK_EN
    logic         brk_rel_q, brk_rel_d;    // break released, sending the mark bit
`endif

    // Burst configuration, captured when leaving IDLE.
    logic [CW-1:0] div_q;
    logic [1:0]    par_q;
    logic          two_q;
    logic [7:0]    guard_q;
    logic          par_en, par_bit;

    assign par_en   = (par_q == 2'b01) || (par_q == 2'b10);
    assign par_bit  = (^sh_q) ^ (par_q == 2'b10);
    assign cnt_last = (cnt_q <= CW'(1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        stop2_d  = stop2_q;
        tx_d     = 1'b1;
        de_d     = 1'b1;
        pop      = 1'b0;
        latch    = 1'b0;
        stop_end = 1'b0;
`ifdef CDC_UART_TX_BREAK_EN
        brk_rel_d = brk_rel_q;
`endif
        case (state_q)
            S_IDLE: begin
                de_d = 1'b0;
`ifdef CDC_UART_TX_BREAK_EN
                if (break_req) begin
                    state_d   = S_BREAK;
                    latch     = 1'b1;
                    brk_rel_d = 1'b0;
                    tx_d      = 1'b0;
                    de_d      = 1'b1;
                end else
`endif
                if (!empty) begin
                    state_d = S_LEAD;
                    latch   = 1'b1;
                    cnt_d   = CW'(de_guard);
                    de_d    = 1'b1;
                end
            end
            S_LEAD: begin
                // A zero guard still spends one cycle here (counter reads 0).
                if (cnt_last) begin
                    state_d = S_START;
                    pop     = 1'b1;
                    cnt_d   = div_q;
                    tx_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (cnt_last) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    cnt_d   = div_q;
                    tx_d    = sh_q[0];
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                tx_d = sh_q[bit_q];
                if (cnt_last) begin
                    cnt_d = div_q;
                    bit_d = bit_q + 3'd1;      // wraps to 0 after bit 7
                    if (bit_q == 3'd7) begin
                        if (par_en) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d = S_STOP;
                            stop2_d = 1'b0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d = sh_q[bit_d];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_PARITY: begin
                tx_d = par_bit;
                if (cnt_last) begin
                    state_d = S_STOP;
                    stop2_d = 1'b0;
                    cnt_d   = div_q;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_last) begin
                    if (two_q && !stop2_q) begin
                        stop2_d = 1'b1;
                        cnt_d   = div_q;
                    end else begin
                        stop_end = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_TRAIL: begin
                if (cnt_last) begin
                    state_d = S_IDLE;
                    de_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef CDC_UART_TX_BREAK_EN
            S_BREAK: begin
                if (!brk_rel_q) begin
                    tx_d = 1'b0;
                    if (!break_req) begin
                        brk_rel_d = 1'b1;
                        cnt_d     = div_q;
                        tx_d      = 1'b1;
                    end
                end else if (cnt_last) begin
                    stop_end = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                de_d    = 1'b0;
            end
        endcase

        // End of a stop (or post-break mark) bit: continue the burst with
        // no guard if data is waiting, otherwise start the DE trail.
        if (stop_end) begin
`ifdef CDC_UART_TX_BREAK_EN
            if (break_req) begin
                state_d   = S_BREAK;
                brk_rel_d = 1'b0;
                tx_d      = 1'b0;
            end else
`endif
            if (!empty) begin
                state_d = S_START;
                pop     = 1'b1;
                cnt_d   = div_q;
                tx_d    = 1'b0;
            end else begin
                state_d = S_TRAIL;
                cnt_d   = CW'(guard_q);
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            de_q       <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            s_tready_q <= 1'b0;
            div_q      <= CW'(1);
            par_q      <= 2'b00;
            two_q      <= 1'b0;
            guard_q    <= 8'd0;
`ifdef CDC_UART_TX_BREAK_EN
            brk_rel_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            de_q       <= de_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            // Ready reflects the post-update level, so a pop while full
            // re-opens the input only from the following cycle.
            s_tready_q <= ((wptr_d - rptr_d) != FULL_LVL);
`ifdef CDC_UART_TX_BREAK_EN
            brk_rel_q  <= brk_rel_d;
`endif
            if (latch) begin
                div_q   <= (baud_div == '0) ? CW'(1) : CW'(baud_div);
                par_q   <= parity_mode;
                two_q   <= two_stop;
                guard_q <= de_guard;
            end
        end
    end

    // Storage and shift register need no reset: they are only read after
    // a push / pop has written them.
    always_ff @(posedge hclk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= s_tdata;
        if (pop)  sh_q <= mem_q[rptr_q[AW-1:0]];
    end

    assign s_tready   = s_tready_q;
    assign UART_TX    = tx_q;
    assign UART_DE    = de_q;
    assign busy       = (state_q != S_IDLE) || !empty;
    assign fifo_level = level;

endmodule

// File: tb/tb_cdc_uart_tx.sv
module tb_cdc_uart_tx;

    localparam int DEPTH = 4;
    localparam int DIV_W = 16;

    logic             hclk = 1'b0;
    logic             reset;
    logic             s_tvalid;
    logic             s_tready;
    logic [7:0]       s_tdata;
    logic [DIV_W-1:0] baud_div;
    logic [1:0]       parity_mode;
    logic             two_stop;
    logic [7:0]       de_guard;
    logic             UART_TX;
    logic             UART_DE;
    logic             busy;
    logic [$clog2(DEPTH):0] fifo_level;

    int checks = 0;
    int failures = 0;

    cdc_uart_tx #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .hclk        (hclk),
        .reset       (reset),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tdata     (s_tdata),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .de_guard    (de_guard),
        .UART_TX     (UART_TX),
        .UART_DE     (UART_DE),
        .busy        (busy),
        .fifo_level  (fifo_level)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        chk("push_ready", s_tready, 1'b1);
        s_tvalid = 1'b1;
        s_tdata  = b;
        step();
        s_tvalid = 1'b0;
    endtask

    task automatic wait_tx_low(input string tag);
        int n = 0;
        while (UART_TX !== 1'b0 && n < 2000) begin
            step();
            n++;
        end
        chk(tag, UART_TX, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 20000) begin
            step();
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    // Called in the first cycle of a start bit. Records bit b into bits[b],
    // requires every cycle of each bit to agree and DE to stay high; returns
    // positioned in the first cycle after the frame.
    task automatic cap_bits(input int nb, input int dv, output logic [15:0] bits, output logic ok);
        ok   = 1'b1;
        bits = '0;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < dv; c++) begin
                if (c == 0) bits[b] = UART_TX;
                else if (UART_TX !== bits[b]) ok = 1'b0;
                if (UART_DE !== 1'b1) ok = 1'b0;
                step();
            end
        end
    endtask

    logic [15:0] bits;
    logic        ok;
    logic [7:0]  b4 [8];
    logic [7:0]  rx [8];
    logic        saw_full;
    int          full_bad;
    int          rx_err;

    initial begin
        reset = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00;
        baud_div = 16'd4; parity_mode = 2'b00; two_stop = 1'b0; de_guard = 8'd3;
        b4[0] = 8'h01; b4[1] = 8'h23; b4[2] = 8'h45; b4[3] = 8'h67;
        b4[4] = 8'h89; b4[5] = 8'hAB; b4[6] = 8'hCD; b4[7] = 8'hEF;

        // ---- reset state ----
        repeat (3) step();
        chk("rst_tready", s_tready, 1'b0);
        chk("rst_tx", UART_TX, 1'b1);
        chk("rst_de", UART_DE, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_level", fifo_level, 0);
        reset = 1'b0;
        step();
        chk("post_rst_tready", s_tready, 1'b1);

        // ---- single byte 0xA5, div 4, 8N1, guard 3 ----
        push_byte(8'hA5);
        chk("t1_de_pre", UART_DE, 1'b0);
        chk("t1_level", fifo_level, 1);
        chk("t1_busy", busy, 1'b1);
        step();
        chk("t1_de_rise", UART_DE, 1'b1);
        chk("t1_tx_lead", UART_TX, 1'b1);
        repeat (2) step();
        chk("t1_tx_lead3", UART_TX, 1'b1);
        step();
        chk("t1_start_edge", UART_TX, 1'b0);
        chk("t1_level_start", fifo_level, 0);
        cap_bits(10, 4, bits, ok);
        chk("t1_frame", bits, 16'h034A);
        chk("t1_frame_stable", ok, 1'b1);
        chk("t1_trail1", UART_DE, 1'b1);
        repeat (2) step();
        chk("t1_trail3", UART_DE, 1'b1);
        step();
        chk("t1_de_fall", UART_DE, 1'b0);
        chk("t1_busy_done", busy, 1'b0);

        // ---- parity: div 2, 0x03 even then odd ----
        baud_div = 16'd2; de_guard = 8'd1; parity_mode = 2'b01;
        push_byte(8'h03);
        wait_tx_low("t2e_start");
        cap_bits(11, 2, bits, ok);
        chk("t2_even_frame", bits, 16'h0406);
        chk("t2_even_stable", ok, 1'b1);
        chk("t2_even_end_tx", UART_TX, 1'b1);
        wait_idle("t2_even_idle");
        parity_mode = 2'b10;
        push_byte(8'h03);
        wait_tx_low("t2o_start");
        cap_bits(11, 2, bits, ok);
        chk("t2_odd_frame", bits, 16'h0606);
        chk("t2_odd_stable", ok, 1'b1);
        wait_idle("t2_odd_idle");

        // ---- back-to-back, two stop bits ----
        parity_mode = 2'b00; two_stop = 1'b1; de_guard = 8'd2;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        wait_tx_low("t3_start1");
        chk("t3_level_a", fifo_level, 2);
        cap_bits(11, 2, bits, ok);
        chk("t3_frame1", bits, 16'h0622);
        chk("t3_de1", ok, 1'b1);
        chk("t3_contig1", UART_TX, 1'b0);
        chk("t3_level_b", fifo_level, 1);
        cap_bits(11, 2, bits, ok);
        chk("t3_frame2", bits, 16'h0644);
        chk("t3_de2", ok, 1'b1);
        chk("t3_contig2", UART_TX, 1'b0);
        chk("t3_level_c", fifo_level, 0);
        cap_bits(11, 2, bits, ok);
        chk("t3_frame3", bits, 16'h0666);
        chk("t3_de3", ok, 1'b1);
        chk("t3_trail_de", UART_DE, 1'b1);
        wait_idle("t3_idle");

        // ---- full / backpressure: 8 bytes into a 4-deep FIFO ----
        two_stop = 1'b0; de_guard = 8'd0; baud_div = 16'd100;
        saw_full = 1'b0; full_bad = 0; rx_err = 0;
        fork
            begin : drv
                int i;
                int n;
                logic rdy;
                i = 0; n = 0;
                while (i < 8 && n < 12000) begin
                    s_tvalid = 1'b1;
                    s_tdata  = b4[i];
                    rdy = s_tready;
                    if (fifo_level == DEPTH && s_tready) full_bad++;
                    if (fifo_level == DEPTH && !s_tready) saw_full = 1'b1;
                    step();
                    n++;
                    if (rdy) i++;
                end
                s_tvalid = 1'b0;
            end
            begin : rcv
                for (int k = 0; k < 8; k++) begin
                    int n;
                    logic [7:0] d;
                    n = 0;
                    while (UART_TX !== 1'b0 && n < 3000) begin
                        step();
                        n++;
                    end
                    if (n >= 3000) rx_err++;
                    repeat (50) step();
                    if (UART_TX !== 1'b0) rx_err++;
                    for (int j = 0; j < 8; j++) begin
                        repeat (100) step();
                        d[j] = UART_TX;
                    end
                    repeat (100) step();
                    if (UART_TX !== 1'b1) rx_err++;
                    rx[k] = d;
                end
            end
        join
        for (int k = 0; k < 8; k++) chk($sformatf("t4_byte%0d", k), rx[k], b4[k]);
        chk("t4_full_seen", saw_full, 1'b1);
        chk("t4_ready_at_full", full_bad, 0);
        chk("t4_rx_framing", rx_err, 0);
        wait_idle("t4_idle");
        chk("t4_level_end", fifo_level, 0);

        // ---- reset during DATA bit 3 ----
        baud_div = 16'd4; de_guard = 8'd1;
        push_byte(8'h0F);
        push_byte(8'h77);
        wait_tx_low("t5_start");
        repeat (4 + 12 + 1) step();
        reset = 1'b1;
        step();
        chk("t5_rst_tx", UART_TX, 1'b1);
        chk("t5_rst_de", UART_DE, 1'b0);
        chk("t5_rst_level", fifo_level, 0);
        chk("t5_rst_tready", s_tready, 1'b0);
        reset = 1'b0;
        step();
        chk("t5_tready", s_tready, 1'b1);
        chk("t5_busy", busy, 1'b0);
        push_byte(8'h5A);
        wait_tx_low("t5_start2");
        cap_bits(10, 4, bits, ok);
        chk("t5_frame", bits, 16'h02B4);
        chk("t5_stable", ok, 1'b1);
        wait_idle("t5_idle");

        // ---- baud_div 0, de_guard 0 ----
        baud_div = 16'd0; de_guard = 8'd0;
        push_byte(8'h96);
        chk("t6_de_pre", UART_DE, 1'b0);
        step();
        chk("t6_lead_de", UART_DE, 1'b1);
        chk("t6_lead_tx", UART_TX, 1'b1);
        step();
        chk("t6_start", UART_TX, 1'b0);
        cap_bits(10, 1, bits, ok);
        chk("t6_frame", bits, 16'h032C);
        chk("t6_stable", ok, 1'b1);
        chk("t6_trail_de", UART_DE, 1'b1);
        step();
        chk("t6_de_fall", UART_DE, 1'b0);
        chk("t6_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
